// File: rtl/inst_encoder_writer_if.sv
// Instruction-beat stream and memory write bus of inst_encoder_writer.
// slave is the encoder's view; master is the view of whatever feeds it and owns the memory.
interface inst_encoder_writer_if;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm64;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;

    modport slave (
        input  in_valid, in_last, opcode, funct3, funct7, rs1, rs2, rd, imm64, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_last, opcode, funct3, funct7, rs1, rs2, rd, imm64, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_encoder_writer.sv
// Encodes RISC-V R/I/S/B instruction beats and writes them to sequential addresses via a 2-entry FIFO.
// Optional macro ENC_IMM_RANGE_CHECK_EN drops beats whose immediate does not fit 12 signed bits.
module inst_encoder_writer #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [63:0]        base_addr,
    inst_encoder_writer_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   inst_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_cnt;
    logic [63:0] addr;
    logic [CNT_W-1:0] count_q;
    logic [31:0] enc_word;
    logic        is_r;
    logic        imm_bad;
    logic        fifo_empty;
    logic        fifo_full;
    logic        accept;
    logic        push;
    logic        pop;
    logic        load_start;

    assign fifo_empty = (fifo_cnt == 2'd0);
    assign fifo_full  = (fifo_cnt == 2'd2);
    assign load_start = (state == IDLE) && start;

    assign bus.in_ready  = (state == RUN) && !fifo_full;
    assign bus.mem_we    = !fifo_empty;
    assign bus.mem_wdata = fifo_mem[rd_ptr];
    assign bus.mem_addr  = addr;

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && !imm_bad;
    assign pop    = bus.mem_we && bus.mem_ready;

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign inst_count = count_q;

    assign is_r = (bus.opcode == 7'b0110011);

    always_comb begin
        enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        if (is_r) begin
            enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        end else if (bus.opcode[6:5] == 2'b00) begin
            enc_word = {bus.imm64[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        end else if (!bus.opcode[6]) begin
            enc_word = {bus.imm64[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm64[4:0], bus.opcode};
        end else begin
            // Branch immediate counts half-words, so bit 0 of the byte offset is implicit
            enc_word = {bus.imm64[11], bus.imm64[9:4], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm64[3:0], bus.imm64[10], bus.opcode};
        end
    end

`ifdef ENC_IMM_RANGE_CHECK_EN
    logic err_q;

    assign imm_bad = !is_r && (bus.imm64[63:11] != {53{bus.imm64[11]}});
    assign err     = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (load_start) begin
            err_q <= 1'b0;
        end else if (accept && imm_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_imm_hi;

    assign imm_bad       = 1'b0;
    assign err           = 1'b0;
    assign unused_imm_hi = ^bus.imm64[63:12];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = RUN;
            RUN:   if (accept && bus.in_last) state_next = DRAIN;
            DRAIN: if (fifo_empty) state_next = DONE;
            DONE:  state_next = IDLE;
        endcase
    end

    // in_ready already excludes a full FIFO, so a push never overruns
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_mem[0] <= 32'd0;
            fifo_mem[1] <= 32'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= enc_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr    <= 64'd0;
            count_q <= '0;
        end else if (load_start) begin
            addr    <= base_addr;
            count_q <= '0;
        end else if (pop) begin
            addr    <= addr + 64'd4;
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inst_encoder_writer.sv
// Randomized self-checking bench for inst_encoder_writer against a field-arithmetic reference model.
// Honours ENC_IMM_RANGE_CHECK_EN the same way the design does.
module tb_inst_encoder_writer;

    localparam int CNT_W = 16;

`ifdef ENC_IMM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        last;
        logic [32:0] golden;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [63:0]      base_addr;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] inst_count;

    int               n_checks = 0;
    int               n_fail = 0;
    bit               monitor_en = 1'b0;
    bit               load_active = 1'b0;
    logic [63:0]      exp_addr = 64'd0;
    logic [CNT_W-1:0] exp_count = '0;
    logic             exp_err = 1'b0;
    logic [31:0]      exp_q[$];
    logic [32:0]      gold_q[$];
    logic [32:0]      cur_golden = 33'd0;
    beat_t            stim_q[$];
    int               ready_low = 0;
    bit               ready_rand = 1'b0;

    inst_encoder_writer_if bus();

    inst_encoder_writer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .inst_count (inst_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoding built from field weights rather than bit concatenation
    function automatic logic [31:0] model_encode(input beat_t b);
        longint unsigned op  = longint'(b.opcode);
        longint unsigned f3  = longint'(b.funct3);
        longint unsigned f7  = longint'(b.funct7);
        longint unsigned r1  = longint'(b.rs1);
        longint unsigned r2  = longint'(b.rs2);
        longint unsigned rdv = longint'(b.rd);
        longint unsigned imm = b.imm;
        longint unsigned w;
        longint unsigned common = r1 * (1 << 15) + f3 * (1 << 12) + op;
        if (op == 64'h33) begin
            w = f7 * (1 << 25) + r2 * (1 << 20) + rdv * (1 << 7) + common;
        end else if (op < 32) begin
            w = (imm % 4096) * (1 << 20) + rdv * (1 << 7) + common;
        end else if (op < 64) begin
            w = ((imm / 32) % 128) * (1 << 25) + r2 * (1 << 20) + (imm % 32) * (1 << 7) + common;
        end else begin
            w = ((imm / 2048) % 2) * 64'h8000_0000 + ((imm / 16) % 64) * (1 << 25)
              + r2 * (1 << 20) + (imm % 16) * (1 << 8) + ((imm / 1024) % 2) * (1 << 7) + common;
        end
        return 32'(w);
    endfunction

    function automatic bit model_imm_ok(input beat_t b);
        longint s = longint'(b.imm);
        if (b.opcode == 7'h33) return 1'b1;
        return (s >= -2048) && (s <= 2047);
    endfunction

    function automatic beat_t make_beat(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv,
                                        input logic [63:0] imm, input logic last, input logic [32:0] golden);
        beat_t b;
        b.opcode = op; b.funct3 = f3; b.funct7 = f7;
        b.rs1 = r1; b.rs2 = r2; b.rd = rdv;
        b.imm = imm; b.last = last; b.golden = golden;
        return b;
    endfunction

    function automatic beat_t random_beat(input logic last);
        beat_t b;
        case ($urandom_range(0, 4))
            0:       b.opcode = 7'h33;
            1:       b.opcode = 7'h13;
            2:       b.opcode = 7'h23;
            3:       b.opcode = 7'h63;
            default: b.opcode = 7'($urandom);
        endcase
        b.funct3 = 3'($urandom);
        b.funct7 = 7'($urandom);
        b.rs1    = 5'($urandom);
        b.rs2    = 5'($urandom);
        b.rd     = 5'($urandom);
        if ($urandom_range(0, 7) == 0) b.imm = {32'($urandom), 32'($urandom)};
        else b.imm = 64'(longint'($urandom_range(0, 4095)) - 2048);
        b.last   = last;
        b.golden = 33'd0;
        return b;
    endfunction

    // Memory-side readiness: forced low for ready_low cycles, otherwise steady or random
    initial begin
        bus.mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_low > 0) begin
                bus.mem_ready = 1'b0;
                ready_low--;
            end else if (ready_rand) begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.mem_ready = 1'b1;
            end
        end
    end

    // Scoreboard: accepted beats become expected writes; each completed write is checked in order
    always @(negedge clk) begin
        if (monitor_en) begin
            beat_t       b;
            logic [32:0] g;
            checkOutput("in_ready", 64'(bus.in_ready), 64'(load_active && (exp_q.size() < 2)));
            checkOutput("mem_we", 64'(bus.mem_we), 64'(exp_q.size() != 0));
            if (bus.mem_we && exp_q.size() != 0) begin
                checkOutput("mem_wdata", 64'(bus.mem_wdata), 64'(exp_q[0]));
                checkOutput("mem_addr", bus.mem_addr, exp_addr);
                g = gold_q[0];
                if (g[32]) checkOutput("golden_word", 64'(bus.mem_wdata), 64'(g[31:0]));
            end
            if (bus.in_valid && bus.in_ready) begin
                b = make_beat(bus.opcode, bus.funct3, bus.funct7, bus.rs1, bus.rs2, bus.rd,
                              bus.imm64, bus.in_last, cur_golden);
                if (!RANGE_CHECK || model_imm_ok(b)) begin
                    exp_q.push_back(model_encode(b));
                    gold_q.push_back(b.golden);
                end else begin
                    exp_err = 1'b1;
                end
                if (b.last) load_active = 1'b0;
            end
            if (bus.mem_we && bus.mem_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                void'(gold_q.pop_front());
                exp_addr  = exp_addr + 64'd4;
                exp_count = exp_count + 1'b1;
            end
        end
    end

    // Runs one load from stim_q; a stray start on the second beat must be ignored
    task automatic applyStimulus(input logic [63:0] base, input bit gaps, input bit wait_done);
        int guard;
        bit acc;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = {32'($urandom), 32'($urandom)};
        exp_addr = base;
        exp_count = '0;
        exp_err = 1'b0;
        load_active = 1'b1;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            bus.opcode = stim_q[i].opcode;
            bus.funct3 = stim_q[i].funct3;
            bus.funct7 = stim_q[i].funct7;
            bus.rs1    = stim_q[i].rs1;
            bus.rs2    = stim_q[i].rs2;
            bus.rd     = stim_q[i].rd;
            bus.imm64  = stim_q[i].imm;
            bus.in_last = stim_q[i].last;
            cur_golden = stim_q[i].golden;
            bus.in_valid = 1'b1;
            if (i == 1) start = 1'b1;
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 300) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                guard++;
            end
            checkOutput("beat_accepted", 64'(acc), 64'd1);
            bus.in_valid = 1'b0;
            bus.in_last = 1'b0;
        end
        if (wait_done) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!done && guard < 300);
            checkOutput("done_seen", 64'(done), 64'd1);
            if (done) begin
                checkOutput("inst_count", 64'(inst_count), 64'(exp_count));
                checkOutput("err", 64'(err), 64'(exp_err));
                checkOutput("busy_in_done", 64'(busy), 64'd1);
                @(negedge clk);
                checkOutput("done_one_cycle", 64'(done), 64'd0);
                checkOutput("busy_after_done", 64'(busy), 64'd0);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = 64'd0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0;
        bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.rd = 5'd0;
        bus.imm64 = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("rst_mem_we", 64'(bus.mem_we), 64'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 64'd0);
        checkOutput("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        checkOutput("rst_count", 64'(inst_count), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        monitor_en = 1'b1;

        $display("[TB] addi single-beat load");
        stim_q.delete();
        stim_q.push_back(make_beat(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 64'd5, 1'b1, 33'h1_0050_0093));
        applyStimulus(64'h1000, 1'b0, 1'b1);
        checkOutput("addi_count", 64'(inst_count), 64'd1);

        $display("[TB] add + sw load");
        stim_q.delete();
        stim_q.push_back(make_beat(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0, 33'h1_0020_81B3));
        stim_q.push_back(make_beat(7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 64'd8, 1'b1, 33'h1_0020_A423));
        applyStimulus(64'h8000_0000_0000_0100, 1'b0, 1'b1);
        checkOutput("add_sw_count", 64'(inst_count), 64'd2);

        $display("[TB] beq load");
        stim_q.delete();
        stim_q.push_back(make_beat(7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 64'd4, 1'b1, 33'h1_0020_8463));
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1);

        $display("[TB] backpressure with three beats");
        stim_q.delete();
        for (int i = 0; i < 3; i++) stim_q.push_back(random_beat(i == 2));
        ready_low = 7;
        applyStimulus(64'h3000, 1'b0, 1'b1);
        checkOutput("bp_count", 64'(inst_count), 64'd3);

        $display("[TB] out-of-range immediate");
        stim_q.delete();
        stim_q.push_back(make_beat(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 64'h800, 1'b1,
                                   RANGE_CHECK ? 33'h0 : 33'h1_8000_0093));
        applyStimulus(64'h4000, 1'b0, 1'b1);
        checkOutput("range_err", 64'(err), RANGE_CHECK ? 64'd1 : 64'd0);
        checkOutput("range_count", 64'(inst_count), RANGE_CHECK ? 64'd0 : 64'd1);

        $display("[TB] randomized loads");
        ready_rand = 1'b1;
        for (int n = 0; n < 8; n++) begin
            int len = $urandom_range(1, 8);
            stim_q.delete();
            for (int i = 0; i < len; i++) stim_q.push_back(random_beat(i == len - 1));
            applyStimulus({32'($urandom), 32'($urandom) & 32'hFFFF_FFFC}, 1'b1, 1'b1);
        end
        ready_rand = 1'b0;

        $display("[TB] reset with two words queued");
        stim_q.delete();
        stim_q.push_back(random_beat(1'b0));
        stim_q.push_back(random_beat(1'b0));
        stim_q[0].opcode = 7'h33;
        stim_q[1].opcode = 7'h33;
        ready_low = 60;
        applyStimulus(64'h2000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("queued_two", 64'(bus.mem_we), 64'd1);
        @(posedge clk); #1;
        monitor_en = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_mem_we", 64'(bus.mem_we), 64'd0);
        checkOutput("mid_rst_count", 64'(inst_count), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("mid_rst_mem_addr", bus.mem_addr, 64'd0);
        ready_low = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("post_rst_mem_we", 64'(bus.mem_we), 64'd0);
        end
        exp_q.delete();
        gold_q.delete();
        load_active = 1'b0;
        monitor_en = 1'b1;

        $display("[TB] load after reset");
        stim_q.delete();
        for (int i = 0; i < 4; i++) stim_q.push_back(random_beat(i == 3));
        applyStimulus(64'h5000, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
